// File: rtl/display_pkg.sv
// Shared seven-segment vocabulary for the stopwatch display encoder and the
// scan decoder, so both sides agree on every active-low gfedcba pattern.
package display_pkg;

   localparam int NUM_DIGITS = 4;

   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h10;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   typedef enum logic [1:0] {
      ST_WAIT   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_HELD   = 2'd2
   } scan_state_e;

   // True when exactly one anode is driven low.
   function automatic logic one_low(input logic [NUM_DIGITS-1:0] an);
      logic ok;
      case (an)
         4'b1110, 4'b1101, 4'b1011, 4'b0111: ok = 1'b1;
         default:                            ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/seg7_to_bcd.sv
// Combinational map from an active-low gfedcba pattern to {valid, blank, bcd}.
module seg7_to_bcd
   import display_pkg::*;
(
   input  logic [6:0] seg,
   output logic       valid,
   output logic       blank,
   output logic [3:0] bcd
);

   // Pattern lookup; anything not in the table is reported as invalid.
   always_comb begin
      valid = 1'b1;
      blank = 1'b0;
      bcd   = 4'd0;
      case (seg)
         SEG_0:     bcd = 4'd0;
         SEG_1:     bcd = 4'd1;
         SEG_2:     bcd = 4'd2;
         SEG_3:     bcd = 4'd3;
         SEG_4:     bcd = 4'd4;
         SEG_5:     bcd = 4'd5;
         SEG_6:     bcd = 4'd6;
         SEG_7:     bcd = 4'd7;
         SEG_8:     bcd = 4'd8;
         SEG_9:     bcd = 4'd9;
         SEG_BLANK: blank = 1'b1;
         default:   valid = 1'b0;
      endcase
   end

endmodule

// File: rtl/seg_scan_decoder.sv
// Samples a multiplexed active-low anode/segment bus and rebuilds the four
// displayed digits, with ghost rejection, legality checks and a stale monitor.
module seg_scan_decoder
   import display_pkg::*;
#(
   parameter int STABLE_CYCLES  = 4,
   parameter int TIMEOUT_CYCLES = 262144
)(
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  an,
   input  logic [6:0]  out,
   output logic [15:0] digits,
   output logic [3:0]  digit_blank,
   output logic        frame_valid,
   output logic        seg_err,
   output logic        stale
);

   localparam int SW = $clog2(STABLE_CYCLES + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [SW-1:0] STABLE_MAX  = SW'(STABLE_CYCLES);
   localparam logic [TW-1:0] TIMEOUT_MAX = TW'(TIMEOUT_CYCLES);
   localparam logic [3:0]    AN_NONE     = 4'hF;

   logic [3:0]      an_r, an_last_r;
   logic [6:0]      out_r, out_last_r;
   scan_state_e     state_r, state_n_s;
   logic [SW-1:0]   cnt_r, cnt_n_s;
   logic [TW-1:0]   tcnt_r, tcnt_n_s;
   logic [NUM_DIGITS-1:0] seen_r, store_mask_s;
   logic [15:0]     shadow_digits_r;
   logic [3:0]      shadow_blank_r;
   logic            same_s, capture_s, store_s, err_s, frame_done_s;
   logic            dec_valid_s, dec_blank_s;
   logic [3:0]      dec_bcd_s;

   seg7_to_bcd u_dec (
      .seg   (out_r),
      .valid (dec_valid_s),
      .blank (dec_blank_s),
      .bcd   (dec_bcd_s)
   );

   // Stability FSM: a capture fires on the cycle the run of identical samples
   // reaches STABLE_CYCLES, then the position is held until the bus moves.
   always_comb begin
      state_n_s = state_r;
      cnt_n_s   = cnt_r;
      same_s    = ({an_r, out_r} == {an_last_r, out_last_r});
      case (state_r)
         ST_WAIT: begin
            if (an_r == AN_NONE) begin
               state_n_s = ST_WAIT;
               cnt_n_s   = '0;
            end else begin
               state_n_s = ST_SETTLE;
               cnt_n_s   = SW'(1);
            end
         end
         ST_SETTLE, ST_HELD: begin
            if (an_r == AN_NONE) begin
               state_n_s = ST_WAIT;
               cnt_n_s   = '0;
            end else if (!same_s) begin
               state_n_s = ST_SETTLE;
               cnt_n_s   = SW'(1);
            end else if (state_r == ST_SETTLE && cnt_r < STABLE_MAX) begin
               cnt_n_s   = cnt_r + SW'(1);
            end else begin
               cnt_n_s   = cnt_r;
            end
         end
         default: begin
            state_n_s = ST_WAIT;
            cnt_n_s   = '0;
         end
      endcase
      if (state_n_s == ST_SETTLE && cnt_n_s == STABLE_MAX) begin
         capture_s = 1'b1;
         state_n_s = ST_HELD;
      end else begin
         capture_s = 1'b0;
      end
   end

   // Capture legality, frame completion and stale-counter next values.
   always_comb begin
      store_s      = capture_s && one_low(an_r) && dec_valid_s;
      err_s        = capture_s && !store_s;
      store_mask_s = store_s ? ~an_r : {NUM_DIGITS{1'b0}};
      frame_done_s = (seen_r == {NUM_DIGITS{1'b1}});
      if (frame_done_s) begin
         tcnt_n_s = '0;
      end else if (tcnt_r < TIMEOUT_MAX) begin
         tcnt_n_s = tcnt_r + TW'(1);
      end else begin
         tcnt_n_s = tcnt_r;
      end
   end

   // All state and outputs; a capture on the frame edge lands in the new mask.
   always_ff @(posedge clk) begin
      if (rst) begin
         an_r            <= AN_NONE;
         out_r           <= SEG_BLANK;
         an_last_r       <= AN_NONE;
         out_last_r      <= SEG_BLANK;
         state_r         <= ST_WAIT;
         cnt_r           <= '0;
         tcnt_r          <= '0;
         seen_r          <= '0;
         shadow_digits_r <= 16'h0000;
         shadow_blank_r  <= 4'h0;
         digits          <= 16'h0000;
         digit_blank     <= 4'h0;
         frame_valid     <= 1'b0;
         seg_err         <= 1'b0;
         stale           <= 1'b0;
      end else begin
         an_r       <= an;
         out_r      <= out;
         an_last_r  <= an_r;
         out_last_r <= out_r;
         state_r    <= state_n_s;
         cnt_r      <= cnt_n_s;
         tcnt_r     <= tcnt_n_s;
         stale      <= (tcnt_n_s == TIMEOUT_MAX);
         seg_err    <= err_s;
         seen_r     <= (frame_done_s ? {NUM_DIGITS{1'b0}} : seen_r) | store_mask_s;
         for (int i = 0; i < NUM_DIGITS; i++) begin
            if (store_mask_s[i]) begin
               shadow_digits_r[4*i +: 4] <= dec_bcd_s;
               shadow_blank_r[i]         <= dec_blank_s;
            end
         end
         frame_valid <= frame_done_s;
         if (frame_done_s) begin
            digits      <= shadow_digits_r;
            digit_blank <= shadow_blank_r;
         end
      end
   end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Scoreboard bench: scans push expected frames, a negedge monitor pops and
// compares them whenever frame_valid pulses and tallies seg_err pulses.
module tb_seg_scan_decoder;

   typedef struct packed {
      logic [15:0] d;
      logic [3:0]  b;
   } frame_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  an  = 4'hF;
   logic [6:0]  out = 7'h7F;
   logic [15:0] digits;
   logic [3:0]  digit_blank;
   logic        frame_valid, seg_err, stale;

   int     n_cmp = 0;
   int     n_bad = 0;
   int     frames = 0;
   int     errs = 0;
   int     f0, e0;
   frame_t exp_q[$];
   frame_t got_f, exp_f;

   seg_scan_decoder #(.STABLE_CYCLES(4), .TIMEOUT_CYCLES(1000)) dut (
      .clk         (clk),
      .rst         (rst),
      .an          (an),
      .out         (out),
      .digits      (digits),
      .digit_blank (digit_blank),
      .frame_valid (frame_valid),
      .seg_err     (seg_err),
      .stale       (stale)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
      n_cmp++;
      if (got !== expv) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, got, expv);
      end
   endtask

   // Monitor: every frame_valid pulse must match the oldest expected frame.
   always @(negedge clk) begin
      if (frame_valid === 1'b1) begin
         frames++;
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_frame: got digits %0h blank %0h expected none", digits, digit_blank);
         end else begin
            exp_f = exp_q.pop_front();
            got_f = '{d: digits, b: digit_blank};
            check("frame_digits", {16'h0, got_f.d}, {16'h0, exp_f.d});
            check("frame_blank",  {28'h0, got_f.b}, {28'h0, exp_f.b});
            check("stale_on_frame", {31'h0, stale}, 32'h0);
         end
      end
      if (seg_err === 1'b1) errs++;
   end

   task automatic drive(input logic [3:0] a, input logic [6:0] o, input int n);
      an  = a;
      out = o;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // pats = {an[3] pattern, an[2], an[1], an[0]}; out lags the anode by lag cycles.
   task automatic scan4(input logic [27:0] pats, input int lag);
      logic [3:0] a;
      for (int k = 3; k >= 0; k--) begin
         a    = 4'hF;
         a[k] = 1'b0;
         if (lag > 0) drive(a, out, lag);
         drive(a, pats[7*k +: 7], 200 - lag);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_digits"}, {16'h0, digits}, 32'h0);
      check({tag, "_blank"},  {28'h0, digit_blank}, 32'h0);
      check({tag, "_fvalid"}, {31'h0, frame_valid}, 32'h0);
      check({tag, "_segerr"}, {31'h0, seg_err}, 32'h0);
      check({tag, "_stale"},  {31'h0, stale}, 32'h0);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      do_reset();
      check_reset_outputs("reset");

      // Plain scan of "1234", twice: one frame per scan, no errors.
      e0 = errs;
      exp_q.push_back('{d: 16'h1234, b: 4'h0});
      scan4({7'h79, 7'h24, 7'h30, 7'h19}, 0);
      exp_q.push_back('{d: 16'h1234, b: 4'h0});
      scan4({7'h79, 7'h24, 7'h30, 7'h19}, 0);
      check("scan_pending", exp_q.size(), 32'h0);
      check("scan_frames", frames, 32'd2);
      check("scan_segerr", errs - e0, 32'h0);

      // Segment pattern lags the anode by 2 cycles: mixed sample never captured.
      e0 = errs;
      exp_q.push_back('{d: 16'h5678, b: 4'h0});
      scan4({7'h12, 7'h02, 7'h78, 7'h00}, 2);
      check("glitch_pending", exp_q.size(), 32'h0);
      check("glitch_segerr", errs - e0, 32'h0);

      // Illegal segment pattern on an[2] withholds the frame until fixed.
      e0 = errs;
      f0 = frames;
      drive(4'b0111, 7'h79, 200);
      drive(4'b1101, 7'h30, 200);
      drive(4'b1110, 7'h19, 200);
      drive(4'b1011, 7'h55, 10);
      drive(4'hF, 7'h7F, 20);
      check("badseg_segerr", errs - e0, 32'h1);
      check("badseg_withheld", frames - f0, 32'h0);
      exp_q.push_back('{d: 16'h1234, b: 4'h0});
      drive(4'b1011, 7'h24, 200);
      check("badseg_recovered", frames - f0, 32'h1);

      // Two anodes low at once.
      e0 = errs;
      f0 = frames;
      drive(4'b0011, 7'h79, 20);
      check("badan_segerr", errs - e0, 32'h1);
      check("badan_noframe", frames - f0, 32'h0);

      // Blank scan, then "0930".
      exp_q.push_back('{d: 16'h0000, b: 4'hF});
      scan4({7'h7F, 7'h7F, 7'h7F, 7'h7F}, 0);
      exp_q.push_back('{d: 16'h0930, b: 4'h0});
      scan4({7'h40, 7'h10, 7'h30, 7'h40}, 0);
      check("blink_pending", exp_q.size(), 32'h0);

      // Stale after exactly 1000 idle cycles; cleared by the next frame.
      an  = 4'hF;
      out = 7'h7F;
      do_reset();
      repeat (999) @(posedge clk);
      #1;
      check("stale_999", {31'h0, stale}, 32'h0);
      @(posedge clk);
      #1;
      check("stale_1000", {31'h0, stale}, 32'h1);
      drive(4'b0111, 7'h12, 200);
      drive(4'b1011, 7'h02, 200);
      drive(4'b1101, 7'h78, 200);
      check("stale_held", {31'h0, stale}, 32'h1);
      exp_q.push_back('{d: 16'h5678, b: 4'h0});
      drive(4'b1110, 7'h00, 200);
      check("stale_pending", exp_q.size(), 32'h0);

      // Reset after three captures discards the partial frame.
      drive(4'b0111, 7'h10, 200);
      drive(4'b1011, 7'h00, 200);
      drive(4'b1101, 7'h78, 200);
      do_reset();
      check_reset_outputs("midrst");
      f0 = frames;
      drive(4'b1110, 7'h19, 200);
      check("midrst_noframe", frames - f0, 32'h0);
      exp_q.push_back('{d: 16'h9874, b: 4'h0});
      scan4({7'h10, 7'h00, 7'h78, 7'h19}, 0);
      check("midrst_frames", frames - f0, 32'h1);

      repeat (4) @(posedge clk);
      #1;
      check("final_pending", exp_q.size(), 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
